ristretto_pipe_elastic_reg: RTL and testbench

//  Parametrised elastic pipeline register for inter-stage boundaries (dec->exe, exe->mem, ...).
//  - Replaces one-shot new-instruction pulse + pending-flag scheme with valid/ready handshake.
//  - Depth-entry circular buffer absorbs back-pressure without losing instructions.
//  - Pipeline Control Unit adds stall_i (freeze output side) and flush_i (drop all contents).

---
 rtl/ristretto_pipe_elastic_reg.sv | 128 ++++++++++++
 tb/tb_ristretto_pipe_elastic_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ristretto_pipe_elastic_reg.sv
// ristretto_pipe_elastic_reg
//   Elastic valid/ready pipeline register for inter-stage boundaries (dec->exe,
//   exe->mem, ...). A Depth-entry circular buffer absorbs back-pressure; the
//   pipeline control unit can freeze the output side (stall) or drop all
//   contents (flush).
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   pip_valid_i/ready_o   upstream handshake, pip_data_i payload
//   pip_valid_o/ready_i   downstream handshake, pip_data_o head payload
//   pip_count_o           current occupancy
//   pip_stall_i           suppress pop this cycle (head held)
//   pip_flush_i           discard all entries and the incoming payload
//   pip_stall_cnt_o       cycles with valid head but no pop
//   pip_flush_cnt_o       entries discarded by flushes
//
// Configuration
//   RISTRETTO_PIPE_PERF_EN  when defined, the saturating performance counters
//                           are built; otherwise both counter outputs are 0.
module ristretto_pipe_elastic_reg #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pip_valid_i,
  output logic                         pip_ready_o,
  input  logic [DataWidth-1:0]         pip_data_i,
  output logic                         pip_valid_o,
  input  logic                         pip_ready_i,
  output logic [DataWidth-1:0]         pip_data_o,
  output logic [$clog2(Depth+1)-1:0]   pip_count_o,
  input  logic                         pip_stall_i,
  input  logic                         pip_flush_i,
  output logic [CntWidth-1:0]          pip_stall_cnt_o,
  output logic [CntWidth-1:0]          pip_flush_cnt_o
);

  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned CountWidth = $clog2(Depth + 1);

  logic [DataWidth-1:0]  mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  valid_q, ready_q;
  logic                  push_c, pop_c;

  // Handshake qualification and next-state pointer/occupancy
  always_comb begin
    push_c   = pip_valid_i & ready_q & ~pip_flush_i;
    pop_c    = valid_q & pip_ready_i & ~pip_stall_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pip_flush_i) begin
      // Flush empties the buffer by snapping the read pointer onto the write pointer
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CountWidth'(1);
        2'b01:   count_d = count_q - CountWidth'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and handshake-flag registers; ready/valid registered from next count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      ready_q  <= (count_d < CountWidth'(Depth));
    end
  end

  // Payload storage, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= pip_data_i;
  end

  assign pip_valid_o = valid_q;
  assign pip_ready_o = ready_q;
  assign pip_count_o = count_q;
  // Head is forced to zero while empty so reset presents a clean bus
  assign pip_data_o  = valid_q ? mem_q[rd_ptr_q] : '0;

`ifdef RISTRETTO_PIPE_PERF_EN
  localparam int unsigned SumWidth = CntWidth + 1;

  logic [CntWidth-1:0] stall_cnt_q, flush_cnt_q;
  logic [SumWidth-1:0] flush_sum_c;

  always_comb begin
    flush_sum_c = SumWidth'(flush_cnt_q) + SumWidth'(count_q);
  end

  // Saturating counters: stalled-head cycles and flushed entries
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (valid_q && !pop_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CntWidth'(1);
      if (pip_flush_i) flush_cnt_q <= flush_sum_c[CntWidth] ? '1 : flush_sum_c[CntWidth-1:0];
    end
  end

  assign pip_stall_cnt_o = stall_cnt_q;
  assign pip_flush_cnt_o = flush_cnt_q;
`else
  assign pip_stall_cnt_o = '0;
  assign pip_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ristretto_pipe_elastic_reg.sv
// tb_ristretto_pipe_elastic_reg
//   Directed plus randomized stimulus against a queue-based reference model.
//   The driver applies inputs just after each rising edge; the monitor samples
//   on the falling edge, compares the DUT against the model and then advances
//   the model by the handshake that will take place on the next rising edge.
module tb_ristretto_pipe_elastic_reg;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 32;
  localparam int unsigned QW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          pip_valid_i = 1'b0;
  logic          pip_ready_o;
  logic [DW-1:0] pip_data_i = '0;
  logic          pip_valid_o;
  logic          pip_ready_i = 1'b0;
  logic [DW-1:0] pip_data_o;
  logic [QW-1:0] pip_count_o;
  logic          pip_stall_i = 1'b0;
  logic          pip_flush_i = 1'b0;
  logic [CW-1:0] pip_stall_cnt_o;
  logic [CW-1:0] pip_flush_cnt_o;

  always #5 clk = ~clk;

  ristretto_pipe_elastic_reg #(
    .DataWidth(DW), .Depth(DEPTH), .CntWidth(CW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .pip_valid_i    (pip_valid_i),
    .pip_ready_o    (pip_ready_o),
    .pip_data_i     (pip_data_i),
    .pip_valid_o    (pip_valid_o),
    .pip_ready_i    (pip_ready_i),
    .pip_data_o     (pip_data_o),
    .pip_count_o    (pip_count_o),
    .pip_stall_i    (pip_stall_i),
    .pip_flush_i    (pip_flush_i),
    .pip_stall_cnt_o(pip_stall_cnt_o),
    .pip_flush_cnt_o(pip_flush_cnt_o)
  );

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic [63:0]   m_stall_cnt = '0;
  logic [63:0]   m_flush_cnt = '0;
  int            n_accepted = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  localparam logic [63:0] CntMax = (64'd1 << CW) - 64'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int  sz;
    bit  m_push, m_pop;
    if (rst_i) begin
      exp_q.delete();
      m_stall_cnt = '0;
      m_flush_cnt = '0;
    end
    sz = exp_q.size();
    chk("valid_o", 64'(pip_valid_o), 64'(sz != 0));
    chk("ready_o", 64'(pip_ready_o), 64'(sz < DEPTH));
    chk("count_o", 64'(pip_count_o), 64'(sz));
    if (sz != 0) chk("data_o", 64'(pip_data_o), 64'(exp_q[0]));
`ifdef RISTRETTO_PIPE_PERF_EN
    chk("stall_cnt", 64'(pip_stall_cnt_o), m_stall_cnt);
    chk("flush_cnt", 64'(pip_flush_cnt_o), m_flush_cnt);
`else
    chk("stall_cnt", 64'(pip_stall_cnt_o), 64'd0);
    chk("flush_cnt", 64'(pip_flush_cnt_o), 64'd0);
`endif
    if (!rst_i) begin
      m_push = pip_valid_i && (sz < DEPTH) && !pip_flush_i;
      m_pop  = (sz != 0) && pip_ready_i && !pip_stall_i;
      if (sz != 0 && !m_pop && m_stall_cnt != CntMax) m_stall_cnt = m_stall_cnt + 64'd1;
      if (pip_flush_i) begin
        m_flush_cnt = (m_flush_cnt + 64'(sz) > CntMax) ? CntMax : m_flush_cnt + 64'(sz);
        exp_q.delete();
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) begin
          exp_q.push_back(pip_data_i);
          n_accepted++;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r,
                     input logic s, input logic f, input logic x);
    @(posedge clk);
    #1;
    pip_valid_i = v;
    pip_data_i  = d;
    pip_ready_i = r;
    pip_stall_i = s;
    pip_flush_i = f;
    rst_i       = x;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, r, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int target;
    int budget;
    // Reset, then reset asserted with two entries held
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Streaming with a consumer always ready
    cyc(1'b1, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Back-pressure: overfill by one, then release
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, DW'(32'h11 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 3, 1'b1);

    // Stall holds the head for three cycles
    cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Flush with three entries and an incoming payload
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Wrap: values 0..9 in order with random consumer readiness
    target = n_accepted + 10;
    budget = 0;
    while (n_accepted < target && budget < 300) begin
      cyc(1'b1, DW'(n_accepted - target + 10), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      budget++;
    end
    if (budget >= 300) chk("wrap_timeout", 64'(n_accepted), 64'(target));
    idle(DEPTH + 2, 1'b1);

    // Randomized traffic including stalls, flushes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), DW'($urandom()), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 199) == 0));
    end
    idle(DEPTH + 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
